// File: rtl/sampler_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sampler_ctrl_pkg
// Purpose  : Shared definitions for the sampler capture sequencer: sampler
//            register addresses, ctrl-register bit positions, FSM state
//            encoding, status codes and a ctrl-word builder.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package sampler_ctrl_pkg;

  // Sampler register addresses
  localparam logic [4:0] C_ADDR_CTRL   = 5'h00;
  localparam logic [4:0] C_ADDR_PERIOD = 5'h04;
  localparam logic [4:0] C_ADDR_MASK   = 5'h08;
  localparam logic [4:0] C_ADDR_IDX_LO = 5'h18;
  localparam logic [4:0] C_ADDR_IDX_HI = 5'h1C;

  // Ctrl register bit positions
  localparam int C_CTRL_ENABLE_BIT    = 0;
  localparam int C_CTRL_CLR_TIMER_BIT = 1;
  localparam int C_CTRL_CLR_PIPE_BIT  = 2;
  localparam int C_CTRL_LOGCH_LSB     = 4;

  // Capture end status codes
  localparam logic [1:0] C_STATUS_LIMIT    = 2'd0;
  localparam logic [1:0] C_STATUS_ABORT    = 2'd1;
  localparam logic [1:0] C_STATUS_OVERFLOW = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_PERIOD = 4'd1,
    ST_WR_MASK   = 4'd2,
    ST_WR_CLEAR  = 4'd3,
    ST_WR_ENABLE = 4'd4,
    ST_RUN       = 4'd5,
    ST_WR_STOP   = 4'd6,
    ST_WR_UNMASK = 4'd7,
    ST_RD_IDX_LO = 4'd8,
    ST_RD_IDX_HI = 4'd9,
    ST_DONE      = 4'd10
  } state_e;

  function automatic logic [31:0] ctrl_word(input logic [2:0] log_ch,
                                            input logic       enable,
                                            input logic       clr_timer,
                                            input logic       clr_pipe);
    logic [31:0] w;
    w = '0;
    w[C_CTRL_ENABLE_BIT]       = enable;
    w[C_CTRL_CLR_TIMER_BIT]    = clr_timer;
    w[C_CTRL_CLR_PIPE_BIT]     = clr_pipe;
    w[C_CTRL_LOGCH_LSB +: 3]   = log_ch;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sampler_capture_ctrl_reg_access.sv
`default_nettype none
// ============================================================================
// Module   : sampler_reg_access
// Purpose  : Single-outstanding access engine for the sampler register port.
//            A request is turned into a one-cycle registered s_avalid; the
//            matching s_bvalid is reported back as ack with its read data.
// Ports    : clk, rst             - clock, async active-high reset
//            req/req_we/req_addr/req_wdata - access request from the FSM
//            ack/rdata            - response toward the FSM
//            s_avalid/s_awe/s_aaddr/s_adata - sampler request (registered)
//            s_bvalid/s_bdata     - sampler response
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module sampler_reg_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        s_avalid,
  output logic        s_awe,
  output logic [4:0]  s_aaddr,
  output logic [31:0] s_adata,
  input  logic        s_bvalid,
  input  logic [31:0] s_bdata
);

  logic        avalid_q, avalid_d;
  logic        awe_q, awe_d;
  logic [4:0]  aaddr_q, aaddr_d;
  logic [31:0] adata_q, adata_d;
  logic        pend_q, pend_d;
  logic        issue;

  // A response is only accepted while an access is outstanding and not in
  // the very cycle the request is on the bus; stray strobes are dropped.
  assign ack   = s_bvalid && pend_q && !avalid_q;
  assign rdata = s_bdata;
  // The FSM chains the next access in the same cycle as ack, so the
  // completing access frees the slot immediately.
  assign issue = req && (!pend_q || ack);

  always_comb begin
    avalid_d = issue;
    awe_d    = issue && req_we;
    aaddr_d  = issue ? req_addr  : 5'd0;
    adata_d  = issue ? req_wdata : 32'd0;
    pend_d   = pend_q;
    if (ack)   pend_d = 1'b0;
    if (issue) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avalid_q <= 1'b0;
      awe_q    <= 1'b0;
      aaddr_q  <= 5'd0;
      adata_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      avalid_q <= avalid_d;
      awe_q    <= awe_d;
      aaddr_q  <= aaddr_d;
      adata_q  <= adata_d;
      pend_q   <= pend_d;
    end
  end

  assign s_avalid = avalid_q;
  assign s_awe    = awe_q;
  assign s_aaddr  = aaddr_q;
  assign s_adata  = adata_q;

endmodule
`default_nettype wire

// File: rtl/sampler_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sampler_capture_ctrl
// Purpose  : Capture sequencer for the logic-analyzer sampler. Programs
//            period / edge masks / channel count, clears the pipeline,
//            enables sampling, counts compressed words until limit, abort
//            or overflow, then stops sampling and reports a status code.
// Ports    : clk, rst                 - clock, async active-high reset
//            start, abort             - host command pulses
//            cfg_*                    - capture configuration (latched at start)
//            busy, done, status, word_count - capture status
//            s_avalid/s_awe/s_aaddr/s_adata/s_bvalid/s_bdata - sampler regs
//            s_out_valid, s_overflow  - sampler compressed-word strobe / flag
//            sample_index             - 64-bit sample index (readback only)
// Options  : SAMPLER_CAPTURE_READBACK_EN - read the sample index (0x18/0x1C)
//            after stopping and expose it on sample_index.
// Revision : 1.0 - initial release
// ============================================================================
module sampler_capture_ctrl
  import sampler_ctrl_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cfg_period,
  input  logic [15:0]       cfg_rise_mask,
  input  logic [15:0]       cfg_fall_mask,
  input  logic [2:0]        cfg_log_channels,
  input  logic [WORD_W-1:0] cfg_word_limit,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [WORD_W-1:0] word_count,
  output logic              s_avalid,
  output logic              s_awe,
  output logic [4:0]        s_aaddr,
  output logic [31:0]       s_adata,
  input  logic              s_bvalid,
  input  logic [31:0]       s_bdata,
  input  logic              s_out_valid,
  input  logic              s_overflow
`ifdef SAMPLER_CAPTURE_READBACK_EN
  ,
  output logic [63:0]       sample_index
`endif
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [WORD_W-1:0] word_count_q, word_count_d;
  logic              abort_pend_q, abort_pend_d;
  logic [31:0]       period_q, period_d;
  logic [15:0]       rise_q, rise_d;
  logic [15:0]       fall_q, fall_d;
  logic [2:0]        log_ch_q, log_ch_d;
  logic [WORD_W-1:0] limit_q, limit_d;

  logic              start_acc;
  logic              limit_hit;
  logic              acc_req, acc_we, acc_ack;
  logic [4:0]        acc_addr;
  logic [31:0]       acc_wdata, acc_rdata;

  assign start_acc = (state_q == ST_IDLE) && start;

  // Configuration is captured once per capture; changes on cfg_* while busy
  // have no effect.
  always_comb begin
    period_d = period_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    log_ch_d = log_ch_q;
    limit_d  = limit_q;
    if (start_acc) begin
      period_d = cfg_period;
      rise_d   = cfg_rise_mask;
      fall_d   = cfg_fall_mask;
      log_ch_d = cfg_log_channels;
      limit_d  = cfg_word_limit;
    end
  end

  always_comb begin
    word_count_d = word_count_q;
    if (start_acc) begin
      word_count_d = '0;
    end else if ((state_q == ST_RUN) && s_out_valid) begin
      word_count_d = word_count_q + {{(WORD_W-1){1'b0}}, 1'b1};
    end
  end

  // Compared against the updated count so the limiting word itself ends RUN.
  assign limit_hit = (limit_q != '0) && (word_count_d == limit_q);

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_WR_PERIOD;
          status_d     = C_STATUS_LIMIT;
          abort_pend_d = 1'b0;
        end
      end
      ST_WR_PERIOD, ST_WR_MASK, ST_WR_CLEAR, ST_WR_ENABLE: begin
        // An abort here cannot cut the access short; it is remembered and
        // honoured once the outstanding write completes.
        if (abort) abort_pend_d = 1'b1;
        if (acc_ack) begin
          if (abort || abort_pend_q) begin
            state_d  = ST_WR_STOP;
            status_d = C_STATUS_ABORT;
          end else begin
            case (state_q)
              ST_WR_PERIOD: state_d = ST_WR_MASK;
              ST_WR_MASK:   state_d = ST_WR_CLEAR;
              ST_WR_CLEAR:  state_d = ST_WR_ENABLE;
              default:      state_d = ST_RUN;
            endcase
          end
        end
      end
      ST_RUN: begin
        // Priority: overflow, then abort, then word limit.
        if (s_overflow) begin
          state_d  = ST_WR_STOP;
          status_d = C_STATUS_OVERFLOW;
        end else if (abort) begin
          state_d  = ST_WR_STOP;
          status_d = C_STATUS_ABORT;
        end else if (limit_hit) begin
          state_d  = ST_WR_STOP;
          status_d = C_STATUS_LIMIT;
        end
      end
      ST_WR_STOP: begin
        if (acc_ack) state_d = ST_WR_UNMASK;
      end
      ST_WR_UNMASK: begin
`ifdef SAMPLER_CAPTURE_READBACK_EN
        if (acc_ack) state_d = ST_RD_IDX_LO;
`else
        if (acc_ack) state_d = ST_DONE;
`endif
      end
`ifdef SAMPLER_CAPTURE_READBACK_EN
      ST_RD_IDX_LO: begin
        if (acc_ack) state_d = ST_RD_IDX_HI;
      end
      ST_RD_IDX_HI: begin
        if (acc_ack) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Each access state is entered exactly once per capture, so the access is
  // requested on the transition into it; this puts s_avalid in the first
  // cycle of the state.
  always_comb begin
    acc_req   = 1'b0;
    acc_we    = 1'b1;
    acc_addr  = C_ADDR_CTRL;
    acc_wdata = 32'd0;
    if (state_d != state_q) begin
      case (state_d)
        ST_WR_PERIOD: begin
          acc_req   = 1'b1;
          acc_addr  = C_ADDR_PERIOD;
          acc_wdata = period_d;
        end
        ST_WR_MASK: begin
          acc_req   = 1'b1;
          acc_addr  = C_ADDR_MASK;
          acc_wdata = {rise_d, fall_d};
        end
        ST_WR_CLEAR: begin
          acc_req   = 1'b1;
          acc_wdata = ctrl_word(log_ch_d, 1'b0, 1'b1, 1'b1);
        end
        ST_WR_ENABLE: begin
          acc_req   = 1'b1;
          acc_wdata = ctrl_word(log_ch_d, 1'b1, 1'b0, 1'b0);
        end
        ST_WR_STOP: begin
          acc_req   = 1'b1;
          acc_wdata = ctrl_word(log_ch_d, 1'b0, 1'b0, 1'b0);
        end
        ST_WR_UNMASK: begin
          acc_req   = 1'b1;
          acc_addr  = C_ADDR_MASK;
        end
        ST_RD_IDX_LO: begin
          acc_req   = 1'b1;
          acc_we    = 1'b0;
          acc_addr  = C_ADDR_IDX_LO;
        end
        ST_RD_IDX_HI: begin
          acc_req   = 1'b1;
          acc_we    = 1'b0;
          acc_addr  = C_ADDR_IDX_HI;
        end
        default: begin
          acc_req   = 1'b0;
        end
      endcase
    end
  end

  sampler_reg_access u_reg_access (
    .clk       (clk),
    .rst       (rst),
    .req       (acc_req),
    .req_we    (acc_we),
    .req_addr  (acc_addr),
    .req_wdata (acc_wdata),
    .ack       (acc_ack),
    .rdata     (acc_rdata),
    .s_avalid  (s_avalid),
    .s_awe     (s_awe),
    .s_aaddr   (s_aaddr),
    .s_adata   (s_adata),
    .s_bvalid  (s_bvalid),
    .s_bdata   (s_bdata)
  );

`ifdef SAMPLER_CAPTURE_READBACK_EN
  logic [31:0] idx_lo_q, idx_lo_d;
  logic [31:0] idx_hi_q, idx_hi_d;

  always_comb begin
    idx_lo_d = idx_lo_q;
    idx_hi_d = idx_hi_q;
    if (acc_ack && (state_q == ST_RD_IDX_LO)) idx_lo_d = acc_rdata;
    if (acc_ack && (state_q == ST_RD_IDX_HI)) idx_hi_d = acc_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_lo_q <= 32'd0;
      idx_hi_q <= 32'd0;
    end else begin
      idx_lo_q <= idx_lo_d;
      idx_hi_q <= idx_hi_d;
    end
  end

  assign sample_index = {idx_hi_q, idx_lo_q};
`else
  logic unused_rdata;
  assign unused_rdata = ^acc_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= C_STATUS_LIMIT;
      word_count_q <= '0;
      abort_pend_q <= 1'b0;
      period_q     <= 32'd0;
      rise_q       <= 16'd0;
      fall_q       <= 16'd0;
      log_ch_q     <= 3'd0;
      limit_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      status_q     <= status_d;
      word_count_q <= word_count_d;
      abort_pend_q <= abort_pend_d;
      period_q     <= period_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      log_ch_q     <= log_ch_d;
      limit_q      <= limit_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sampler_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sampler_capture_ctrl
// Purpose  : Directed self-checking bench for sampler_capture_ctrl, with a
//            small sampler register-port responder that logs every access.
// Options  : SAMPLER_CAPTURE_READBACK_EN - also checks index readback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sampler_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic [15:0] cfg_rise_mask = 16'd0;
  logic [15:0] cfg_fall_mask = 16'd0;
  logic [2:0]  cfg_log_channels = 3'd0;
  logic [31:0] cfg_word_limit = 32'd0;
  logic        busy, done;
  logic [1:0]  status;
  logic [31:0] word_count;
  logic        s_avalid, s_awe;
  logic [4:0]  s_aaddr;
  logic [31:0] s_adata;
  logic        s_bvalid = 1'b0;
  logic [31:0] s_bdata = 32'd0;
  logic        s_out_valid = 1'b0;
  logic        s_overflow = 1'b0;

`ifdef SAMPLER_CAPTURE_READBACK_EN
  logic [63:0] sample_index;
  localparam int DONE_LAT = 8;  // cycles from WR_STOP issue to done
  localparam int N_ACC    = 8;
`else
  localparam int DONE_LAT = 4;
  localparam int N_ACC    = 6;
`endif

  sampler_capture_ctrl #(.WORD_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .cfg_period       (cfg_period),
    .cfg_rise_mask    (cfg_rise_mask),
    .cfg_fall_mask    (cfg_fall_mask),
    .cfg_log_channels (cfg_log_channels),
    .cfg_word_limit   (cfg_word_limit),
    .busy             (busy),
    .done             (done),
    .status           (status),
    .word_count       (word_count),
    .s_avalid         (s_avalid),
    .s_awe            (s_awe),
    .s_aaddr          (s_aaddr),
    .s_adata          (s_adata),
    .s_bvalid         (s_bvalid),
    .s_bdata          (s_bdata),
    .s_out_valid      (s_out_valid),
    .s_overflow       (s_overflow)
`ifdef SAMPLER_CAPTURE_READBACK_EN
    ,
    .sample_index     (sample_index)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } acc_t;

  acc_t log_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Sampler responder: answers each request one cycle later, logs it with
  // the cycle number in which s_avalid was high.
  always @(posedge clk) begin
    if (s_avalid) begin
      log_q.push_back('{t: cyc, we: s_awe, a: s_aaddr, d: s_adata});
      s_bdata <= (s_aaddr == 5'h18) ? 32'h0000_0020 :
                 (s_aaddr == 5'h1C) ? 32'h0000_0001 : 32'h0;
    end
    s_bvalid <= s_avalid;
    cyc      <= cyc + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic we,
                         input logic [4:0] a, input logic [31:0] d, input int t);
    if (idx < log_q.size()) begin
      chk({tag, "_acc"},
          {25'd0, log_q[idx].we, log_q[idx].a, (log_q[idx].we ? log_q[idx].d : 32'd0)},
          {25'd0, we, a, d});
      chk({tag, "_cyc"}, 64'(log_q[idx].t), 64'(t));
    end else begin
      chk({tag, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic do_start(input logic [31:0] per, input logic [15:0] r, input logic [15:0] f,
                          input logic [2:0] lc, input logic [31:0] lim, output int s);
    cfg_period = per; cfg_rise_mask = r; cfg_fall_mask = f;
    cfg_log_channels = lc; cfg_word_limit = lim;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    // Scramble the inputs: only the values latched at start may be used.
    cfg_period = 32'hDEAD_BEEF; cfg_rise_mask = 16'hFFFF; cfg_fall_mask = 16'hFFFF;
    cfg_log_channels = 3'd0; cfg_word_limit = 32'd1;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while ((done !== 1'b1) && (lat < budget)) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int s;
    int lat;

    // ---------------- reset state ----------------
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_wcount", 64'(word_count), 64'd0);
    chk("rst_avalid", 64'(s_avalid), 64'd0);
    chk("rst_abus", {26'd0, s_awe, s_aaddr, s_adata}, 64'd0);
`ifdef SAMPLER_CAPTURE_READBACK_EN
    chk("rst_index", sample_index, 64'd0);
`endif
    rst = 1'b0;
    tick(2);

    // ---------------- T1: limit 3 ----------------
    log_q.delete();
    do_start(32'd9, 16'h0, 16'h0, 3'd4, 32'd3, s);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    chk("t1_wcount_clr", 64'(word_count), 64'd0);
    tick(8);                                   // cycle s+9: RUN
    s_out_valid = 1'b1;
    tick(3);                                   // words in s+9..s+11
    s_out_valid = 1'b0;
    chk("t1_stop_issue", {31'd0, s_avalid, s_aaddr, s_adata}, {31'd0, 1'b1, 5'h00, 32'h40});
    wait_done(DONE_LAT + 4, lat);
    chk("t1_done_lat", 64'(lat), 64'(DONE_LAT));
    chk("t1_status", 64'(status), 64'd0);
    chk("t1_wcount", 64'(word_count), 64'd3);
    chk("t1_busy_at_done", 64'(busy), 64'd1);
`ifdef SAMPLER_CAPTURE_READBACK_EN
    chk("t1_index", sample_index, 64'h0000_0001_0000_0020);
`endif
    tick();
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_nacc", 64'(log_q.size()), 64'(N_ACC));
    chk_acc("t1_period", 0, 1'b1, 5'h04, 32'd9,  s + 1);
    chk_acc("t1_mask",   1, 1'b1, 5'h08, 32'd0,  s + 3);
    chk_acc("t1_clear",  2, 1'b1, 5'h00, 32'h46, s + 5);
    chk_acc("t1_enable", 3, 1'b1, 5'h00, 32'h41, s + 7);
    chk_acc("t1_stop",   4, 1'b1, 5'h00, 32'h40, s + 12);
    chk_acc("t1_unmask", 5, 1'b1, 5'h08, 32'd0,  s + 14);
`ifdef SAMPLER_CAPTURE_READBACK_EN
    chk_acc("t1_rd_lo",  6, 1'b0, 5'h18, 32'd0,  s + 16);
    chk_acc("t1_rd_hi",  7, 1'b0, 5'h1C, 32'd0,  s + 18);
`endif
    tick(2);

    // ---------------- T2: unlimited, ten words, abort ----------------
    log_q.delete();
    do_start(32'd20, 16'h00F0, 16'h0F00, 3'd2, 32'd0, s);
    tick(8);
    s_out_valid = 1'b1;
    tick(10);                                  // words in s+9..s+18
    s_out_valid = 1'b0;
    abort = 1'b1;                              // abort sampled in s+19
    tick();
    abort = 1'b0;
    chk("t2_stop_issue", {31'd0, s_avalid, s_aaddr, s_adata}, {31'd0, 1'b1, 5'h00, 32'h20});
    wait_done(DONE_LAT + 4, lat);
    chk("t2_done_lat", 64'(lat), 64'(DONE_LAT));
    chk("t2_status", 64'(status), 64'd1);
    chk("t2_wcount", 64'(word_count), 64'd10);
    chk_acc("t2_period", 0, 1'b1, 5'h04, 32'd20,        s + 1);
    chk_acc("t2_mask",   1, 1'b1, 5'h08, 32'h00F00F00,  s + 3);
    chk_acc("t2_stop",   4, 1'b1, 5'h00, 32'h20,        s + 20);
    chk_acc("t2_unmask", 5, 1'b1, 5'h08, 32'd0,         s + 22);
    tick(3);

    // ---------------- T3: abort during WR_MASK ----------------
    log_q.delete();
    do_start(32'd5, 16'hA5A5, 16'h5A5A, 3'd7, 32'd0, s);
    tick(2);                                   // cycle s+3: mask write on bus
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();                                    // cycle s+5
    chk("t3_stop_issue", {31'd0, s_avalid, s_aaddr, s_adata}, {31'd0, 1'b1, 5'h00, 32'h70});
    wait_done(DONE_LAT + 4, lat);
    chk("t3_done_lat", 64'(lat), 64'(DONE_LAT));
    chk("t3_status", 64'(status), 64'd1);
    chk("t3_wcount", 64'(word_count), 64'd0);
    chk("t3_nacc", 64'(log_q.size()), 64'(N_ACC - 2));
    chk_acc("t3_mask",   1, 1'b1, 5'h08, 32'hA5A55A5A, s + 3);
    chk_acc("t3_stop",   2, 1'b1, 5'h00, 32'h70,       s + 5);
    chk_acc("t3_unmask", 3, 1'b1, 5'h08, 32'd0,        s + 7);
    tick(3);

    // ---------------- T4: stale overflow, then overflow+abort+word ----------------
    log_q.delete();
    s_overflow = 1'b1;                         // left over from a previous capture
    do_start(32'd3, 16'h0001, 16'h0002, 3'd1, 32'd0, s);
    tick(5);                                   // cycle s+6: clear write acknowledged
    s_overflow = 1'b0;
    tick(3);                                   // cycle s+9
    s_out_valid = 1'b1;
    tick(2);                                   // cycle s+11
    s_overflow = 1'b1;
    abort = 1'b1;
    tick();
    s_out_valid = 1'b0; s_overflow = 1'b0; abort = 1'b0;
    chk("t4_stop_issue", {31'd0, s_avalid, s_aaddr, s_adata}, {31'd0, 1'b1, 5'h00, 32'h10});
    wait_done(DONE_LAT + 4, lat);
    chk("t4_done_lat", 64'(lat), 64'(DONE_LAT));
    chk("t4_status", 64'(status), 64'd2);
    chk("t4_wcount", 64'(word_count), 64'd3);
    tick(3);

    // ---------------- T5: idle words and start while busy ignored ----------------
    s_out_valid = 1'b1;
    tick(3);
    s_out_valid = 1'b0;
    tick();
    chk("t5_idle_wcount", 64'(word_count), 64'd3);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    log_q.delete();
    do_start(32'd11, 16'h1111, 16'h2222, 3'd3, 32'd2, s);
    tick();                                    // cycle s+2
    cfg_period = 32'h77; cfg_rise_mask = 16'hFFFF; cfg_fall_mask = 16'hFFFF;
    cfg_word_limit = 32'd9;
    start = 1'b1;
    tick();                                    // cycle s+3
    start = 1'b0;
    chk("t5_mask_kept", {31'd0, s_avalid, s_aaddr, s_adata}, {31'd0, 1'b1, 5'h08, 32'h11112222});
    tick(6);                                   // cycle s+9
    s_out_valid = 1'b1;
    tick(2);                                   // words in s+9, s+10
    s_out_valid = 1'b0;
    chk("t5_stop_issue", {31'd0, s_avalid, s_aaddr, s_adata}, {31'd0, 1'b1, 5'h00, 32'h30});
    wait_done(DONE_LAT + 4, lat);
    chk("t5_done_lat", 64'(lat), 64'(DONE_LAT));
    chk("t5_status", 64'(status), 64'd0);
    chk("t5_wcount", 64'(word_count), 64'd2);
    tick(4);
    chk("t5_no_restart", 64'(busy), 64'd0);
    chk("t5_nacc", 64'(log_q.size()), 64'(N_ACC));
    chk_acc("t5_period", 0, 1'b1, 5'h04, 32'd11, s + 1);

    // ---------------- T6: reset mid-capture ----------------
    do_start(32'd4, 16'h0, 16'h0, 3'd5, 32'd0, s);
    tick(8);
    s_out_valid = 1'b1;
    tick(2);
    chk("t6_wcount_run", 64'(word_count), 64'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_wcount", 64'(word_count), 64'd0);
    chk("t6_rst_avalid", 64'(s_avalid), 64'd0);
`ifdef SAMPLER_CAPTURE_READBACK_EN
    chk("t6_rst_index", sample_index, 64'd0);
`endif
    tick();
    rst = 1'b0;
    tick(3);
    chk("t6_idle_after", {62'd0, busy, s_avalid}, 64'd0);
    chk("t6_wcount_idle", 64'(word_count), 64'd0);
    s_out_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
